// File: rtl/seq_divider.sv
// Iterative restoring divider for unsigned N-bit operands: one trial subtraction
// and one quotient bit per clock, with a start/busy/done handshake.

module seq_divider_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] r,
  input  logic [N-1:0] q,
  input  logic [N-1:0] d,
  output logic [N-1:0] r_next,
  output logic [N-1:0] q_next
);
  logic [N:0] r_sh;
  logic [N:0] t;

  // Shift the next dividend bit into the remainder, then trial-subtract.
  assign r_sh   = {r, q[N-1]};
  assign t      = r_sh - {1'b0, d};
  assign r_next = t[N] ? r_sh[N-1:0] : t[N-1:0];
  assign q_next = {q[N-2:0], ~t[N]};
endmodule

module seq_divider #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  // The stored partial remainder never exceeds the divisor, so its top bit is
  // always zero; only the low N bits are kept, the trial stays N+1 bits wide.
  logic [N-1:0]  r;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic [CW-1:0] cnt;
  logic          z;
  logic [N-1:0]  r_step, q_step;
  logic          accept, last, zero_div;

  assign accept   = start && (state != RUN);
  assign last     = (cnt == CW'(N - 1));
  assign zero_div = (divisor == '0);

  seq_divider_step #(.N(N)) u_step (
    .r      (r),
    .q      (q),
    .d      (d),
    .r_next (r_step),
    .q_next (q_step)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nx = zero_div ? DONE : RUN;
        else        state_nx = IDLE;
      end
      RUN:     if (last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r   <= '0;
      q   <= '0;
      d   <= '0;
      cnt <= '0;
      z   <= 1'b0;
    end else if (accept) begin
      if (zero_div) begin
        // Zero divisor resolves immediately: all-ones quotient, dividend as remainder.
        z <= 1'b1;
        q <= '1;
        r <= dividend;
      end else begin
        z   <= 1'b0;
        q   <= dividend;
        d   <= divisor;
        r   <= '0;
        cnt <= '0;
      end
    end else if (state == RUN) begin
      r   <= r_step;
      q   <= q_step;
      cnt <= cnt + CW'(1);
    end
  end

  assign quotient    = q;
  assign remainder   = r;
  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign div_by_zero = z;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N = 4): latency, boundaries, zero divisor,
// handshake, asynchronous reset and an exhaustive operand sweep.

module tb_seq_divider;
  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  int vectors = 0;
  int miscompares = 0;

  seq_divider #(.N(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input int a, input int b);
    start    = 1'b1;
    dividend = a[N-1:0];
    divisor  = b[N-1:0];
    step();
    start = 1'b0;
  endtask

  // Waits (bounded) for done; lat = sample index after the accepting edge.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 1;
    busy_n = 0;
    while (!done && lat <= 3 * N) begin
      if (busy) busy_n++;
      step();
      lat++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    vectors++;
    if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: q=%0d r=%0d busy=%b done=%b dbz=%b, required all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lat, bn;
    do_start(13, 4);
    wait_done(lat, bn);
    vectors++;
    if (lat != 5 || bn != 4) begin
      miscompares++;
      $display("FAIL basic_timing: done at %0d busy=%0d, required 5 and 4", lat, bn);
    end
    vectors++;
    if (quotient !== 4'd3 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_13_4: q=%0d r=%0d dbz=%b, required 3 1 0", quotient, remainder, div_by_zero);
    end
    step();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 4'd3 || remainder !== 4'd1) begin
      miscompares++;
      $display("FAIL basic_hold: done=%b busy=%b q=%0d r=%0d, required 0 0 3 1",
               done, busy, quotient, remainder);
    end
    step();
  endtask

  task automatic test_boundary();
    int ta[3] = '{15, 3, 15};
    int tb[3] = '{1, 9, 15};
    int tq[3] = '{15, 0, 1};
    int tr[3] = '{0, 3, 0};
    int lat, bn;
    for (int i = 0; i < 3; i++) begin
      do_start(ta[i], tb[i]);
      wait_done(lat, bn);
      vectors++;
      if (quotient !== tq[i][N-1:0] || remainder !== tr[i][N-1:0] || div_by_zero !== 1'b0) begin
        miscompares++;
        $display("FAIL boundary_%0d_%0d: q=%0d r=%0d dbz=%b, required %0d %0d 0",
                 ta[i], tb[i], quotient, remainder, div_by_zero, tq[i], tr[i]);
      end
      step();
    end
  endtask

  task automatic test_div_zero();
    int lat, bn;
    do_start(7, 0);
    wait_done(lat, bn);
    vectors++;
    if (lat != 1 || bn != 0) begin
      miscompares++;
      $display("FAIL dz_timing: done at %0d busy=%0d, required 1 and 0", lat, bn);
    end
    vectors++;
    if (quotient !== 4'd15 || remainder !== 4'd7 || div_by_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL dz_7_0: q=%0d r=%0d dbz=%b, required 15 7 1", quotient, remainder, div_by_zero);
    end
    step();
    do_start(6, 3);
    wait_done(lat, bn);
    vectors++;
    if (quotient !== 4'd2 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL dz_clear_6_3: q=%0d r=%0d dbz=%b, required 2 0 0", quotient, remainder, div_by_zero);
    end
    step();
  endtask

  task automatic test_handshake();
    int lat, bn;
    do_start(9, 2);
    start = 1'b1;
    dividend = 4'd14;
    divisor = 4'd7;
    step();
    start = 1'b0;
    wait_done(lat, bn);
    vectors++;
    if (lat != 4 || quotient !== 4'd4 || remainder !== 4'd1) begin
      miscompares++;
      $display("FAIL hs_ignore: done at %0d q=%0d r=%0d, required 4 4 1", lat, quotient, remainder);
    end
    // Start held through DONE: accepted with no IDLE gap.
    start = 1'b1;
    dividend = 4'd14;
    divisor = 4'd7;
    step();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL hs_b2b_start: busy=%b done=%b, required 1 0", busy, done);
    end
    wait_done(lat, bn);
    vectors++;
    if (lat != 5 || quotient !== 4'd2 || remainder !== 4'd0) begin
      miscompares++;
      $display("FAIL hs_b2b_14_7: done at %0d q=%0d r=%0d, required 5 2 0", lat, quotient, remainder);
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    int lat, bn;
    bit seen_done;
    do_start(11, 3);
    step();
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
      miscompares++;
      $display("FAIL reset_async: q=%0d r=%0d busy=%b done=%b dbz=%b, required all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    step();
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) seen_done = 1'b1;
      step();
    end
    vectors++;
    if (seen_done) begin
      miscompares++;
      $display("FAIL reset_no_done: activity seen after reset=1, required 0");
    end
    do_start(11, 3);
    wait_done(lat, bn);
    vectors++;
    if (quotient !== 4'd3 || remainder !== 4'd2) begin
      miscompares++;
      $display("FAIL reset_rerun_11_3: q=%0d r=%0d, required 3 2", quotient, remainder);
    end
    step();
  endtask

  task automatic test_exhaustive();
    int lat, bn, qi, ri;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_start(a, b);
        wait_done(lat, bn);
        qi = int'(quotient);
        ri = int'(remainder);
        vectors++;
        if (b == 0) begin
          if (qi != 15 || ri != a || div_by_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL exh_%0d_0: q=%0d r=%0d dbz=%b, required 15 %0d 1", a, qi, ri, div_by_zero, a);
          end
        end else begin
          if (qi * b + ri != a || ri >= b || qi != a / b || div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL exh_%0d_%0d: q=%0d r=%0d dbz=%b, required %0d %0d 0",
                     a, b, qi, ri, div_by_zero, a / b, a % b);
          end
        end
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_handshake();
    test_reset_mid_run();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
